// File: rtl/mmc3_pkg.sv
// Shared definitions for the MMC3 (TxROM) mapper: mirroring codes,
// register-select encodings, bank reset values and small mapping helpers.
package mmc3_pkg;

  // Mirroring codes driven on mirr
  localparam logic [2:0] MIRRVER = 3'd0;
  localparam logic [2:0] MIRRHOR = 3'd1;

  // Register select = {memaddr[14:13], memaddr[0]}
  typedef enum logic [2:0] {
    MMC3_BANKSEL   = 3'b000,  // $8000
    MMC3_BANKDATA  = 3'b001,  // $8001
    MMC3_MIRROR    = 3'b010,  // $A000
    MMC3_PRGRAM    = 3'b011,  // $A001 (ignored)
    MMC3_IRQLATCH  = 3'b100,  // $C000
    MMC3_IRQRELOAD = 3'b101,  // $C001
    MMC3_IRQDIS    = 3'b110,  // $E000
    MMC3_IRQEN     = 3'b111   // $E001
  } mmc3_reg_e;

  // Bank registers R7..R0 after reset (index 0 is the rightmost entry)
  localparam logic [7:0][7:0] BANK_RST = {8'd1, 8'd0, 8'd7, 8'd6,
                                          8'd5, 8'd4, 8'd2, 8'd0};

  // Last 8 KB bank number for a PRG size given in 16 KB units
  function automatic logic [7:0] prg_last(input logic [6:0] cnt16k);
    return {cnt16k, 1'b0} - 8'd1;
  endfunction

  // 1 KB CHR bank for the (inversion-adjusted) 1 KB slot a
  function automatic logic [7:0] chr_bank(input logic [7:0][7:0] r,
                                          input logic [2:0] a);
    logic [7:0] b;
    case (a)
      3'd0, 3'd1: b = {r[0][7:1], a[0]};
      3'd2, 3'd3: b = {r[1][7:1], a[0]};
      3'd4:       b = r[2];
      3'd5:       b = r[3];
      3'd6:       b = r[4];
      3'd7:       b = r[5];
      default:    b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mmc3_a12_filter.sv
// PPU A12 rising-edge filter: a sampled high only counts as an edge when it
// follows at least A12LOW cycles without a sampled high.
module a12_filter #(
  parameter int A12LOW = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic a12,
  input  logic valid,
  output logic a12_edge
);

  localparam int CW = (A12LOW < 1) ? 1 : $clog2(A12LOW + 1);
  localparam logic [CW-1:0] LOWMAX = CW'(A12LOW);

  logic [CW-1:0] lowcnt_d;
  logic [CW-1:0] lowcnt_q;
  logic          hi_s;

  assign hi_s     = valid && a12;
  assign a12_edge = hi_s && (lowcnt_q == LOWMAX);

  // Low-time counter: cleared by any sampled high, otherwise counts up and saturates
  always_comb begin
    lowcnt_d = lowcnt_q;
    if (hi_s) begin
      lowcnt_d = '0;
    end else if (lowcnt_q != LOWMAX) begin
      lowcnt_d = lowcnt_q + CW'(1);
    end else begin
      lowcnt_d = lowcnt_q;
    end
  end

  // Low-time counter state; starts saturated so the first high after reset counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lowcnt_q <= LOWMAX;
    end else begin
      lowcnt_q <= lowcnt_d;
    end
  end

endmodule

// File: rtl/mmc3.sv
// MMC3 (TxROM) cartridge mapper: 8 KB PRG banking, 1 KB/2 KB CHR banking and a
// scanline IRQ counter clocked by filtered PPU A12 rising edges.
module mmc3
  import mmc3_pkg::*;
#(
  parameter int PRGAW  = 21,
  parameter int CHRAW  = 21,
  parameter int A12LOW = 3
) (
  input  logic             clk,
  input  logic             reset,
  output logic             irq,
  input  logic [15:0]      memaddr,
  output logic [7:0]       prgrdata,
  input  logic [7:0]       memwdata,
  input  logic             memwr,
  input  logic             prgreq,
  output logic             prgack,
  input  logic [13:0]      vmemaddr,
  output logic [7:0]       chrrdata,
  input  logic             chrreq,
  output logic             chrack,
  output logic [PRGAW-1:0] promaddr,
  input  logic [7:0]       promdata,
  output logic             promreq,
  input  logic             promack,
  output logic [CHRAW-1:0] cromaddr,
  input  logic [7:0]       cromdata,
  output logic             cromreq,
  input  logic             cromack,
  input  logic [127:0]     header,
  output logic [2:0]       mirr
);

  // Register state
  logic [7:0][7:0] bank_d, bank_q;
  logic [2:0]      sel_d, sel_q;
  logic            prgmode_d, prgmode_q;
  logic            chrinv_d, chrinv_q;
  logic [7:0]      latch_d, latch_q;
  logic [7:0]      cnt_d, cnt_q;
  logic            reload_d, reload_q;
  logic            irqen_d, irqen_q;
  logic            irq_d, irq_q;
  logic [2:0]      mirr_d, mirr_q;
  logic            prgreq_q;

  // Combinational helpers
  logic            wr_stb;
  mmc3_reg_e       reg_sel;
  logic            a12_edge;
  logic [7:0]      cnt_next;
  logic [7:0]      last;
  logic [7:0]      slast;
  logic [7:0]      prg_raw;
  logic [7:0]      prg_bank;
  logic [20:0]     prg_full;
  logic [2:0]      chr_slot;
  logic [17:0]     chr_full;
  logic            unused_bits;

  // Bus pass-throughs: no added latency
  assign prgrdata = promdata;
  assign prgack   = promack;
  assign promreq  = prgreq;
  assign chrrdata = cromdata;
  assign chrack   = cromack;
  assign cromreq  = chrreq;

  assign irq  = irq_q;
  assign mirr = mirr_q;

  assign unused_bits = &{1'b0, header[127:39], header[31:0], vmemaddr[13]};

  // One write per rising edge of the CPU request
  assign wr_stb  = memaddr[15] && memwr && prgreq && !prgreq_q;
  assign reg_sel = mmc3_reg_e'({memaddr[14:13], memaddr[0]});

  a12_filter #(
    .A12LOW(A12LOW)
  ) u_a12_filter (
    .clk     (clk),
    .reset   (reset),
    .a12     (vmemaddr[12]),
    .valid   (chrreq),
    .a12_edge(a12_edge)
  );

  // PRG window to 8 KB bank translation, masked to the ROM size
  always_comb begin
    last  = prg_last(header[38:32]);
    slast = last - 8'd1;
    case ({prgmode_q, memaddr[14:13]})
      3'b000:  prg_raw = bank_q[6];
      3'b001:  prg_raw = bank_q[7];
      3'b010:  prg_raw = slast;
      3'b011:  prg_raw = last;
      3'b100:  prg_raw = slast;
      3'b101:  prg_raw = bank_q[7];
      3'b110:  prg_raw = bank_q[6];
      3'b111:  prg_raw = last;
      default: prg_raw = last;
    endcase
    prg_bank = prg_raw & last;
    prg_full = {prg_bank, memaddr[12:0]};
    promaddr = PRGAW'(prg_full);
  end

  // CHR 1 KB slot translation with optional A12 inversion
  always_comb begin
    chr_slot = vmemaddr[12:10] ^ {chrinv_q, 2'b00};
    chr_full = {chr_bank(bank_q, chr_slot), vmemaddr[9:0]};
    cromaddr = CHRAW'(chr_full);
  end

  // Next-state: IRQ counter on filtered edges, then CPU register writes (writes win)
  always_comb begin
    bank_d    = bank_q;
    sel_d     = sel_q;
    prgmode_d = prgmode_q;
    chrinv_d  = chrinv_q;
    latch_d   = latch_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    irqen_d   = irqen_q;
    irq_d     = irq_q;
    mirr_d    = mirr_q;
    cnt_next  = cnt_q;

    if (a12_edge) begin
      if ((cnt_q == 8'd0) || reload_q) begin
        cnt_next = latch_q;
        reload_d = 1'b0;
      end else begin
        cnt_next = cnt_q - 8'd1;
      end
      cnt_d = cnt_next;
      if ((cnt_next == 8'd0) && irqen_q) begin
        irq_d = 1'b1;
      end else begin
        irq_d = irq_q;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (wr_stb) begin
      case (reg_sel)
        MMC3_BANKSEL: begin
          sel_d     = memwdata[2:0];
          prgmode_d = memwdata[6];
          chrinv_d  = memwdata[7];
        end
        MMC3_BANKDATA:  bank_d[sel_q] = memwdata;
        MMC3_MIRROR:    mirr_d = memwdata[0] ? MIRRHOR : MIRRVER;
        MMC3_IRQLATCH:  latch_d = memwdata;
        MMC3_IRQRELOAD: begin
          cnt_d    = 8'd0;
          reload_d = 1'b1;
        end
        MMC3_IRQDIS: begin
          irqen_d = 1'b0;
          irq_d   = 1'b0;
        end
        MMC3_IRQEN:     irqen_d = 1'b1;
        default:        sel_d = sel_q;
      endcase
    end else begin
      sel_d = sel_q;
    end
  end

  // Mapper state registers with asynchronous reset to power-on values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q    <= BANK_RST;
      sel_q     <= 3'd0;
      prgmode_q <= 1'b0;
      chrinv_q  <= 1'b0;
      latch_q   <= 8'd0;
      cnt_q     <= 8'd0;
      reload_q  <= 1'b0;
      irqen_q   <= 1'b0;
      irq_q     <= 1'b0;
      mirr_q    <= MIRRVER;
      prgreq_q  <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      sel_q     <= sel_d;
      prgmode_q <= prgmode_d;
      chrinv_q  <= chrinv_d;
      latch_q   <= latch_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      irqen_q   <= irqen_d;
      irq_q     <= irq_d;
      mirr_q    <= mirr_d;
      prgreq_q  <= prgreq;
    end
  end

endmodule

// File: tb/tb_mmc3.sv
// Directed self-checking bench for the MMC3 mapper.
module tb_mmc3;
  import mmc3_pkg::*;

  logic         clk;
  logic         reset;
  logic         irq;
  logic [15:0]  memaddr;
  logic [7:0]   prgrdata;
  logic [7:0]   memwdata;
  logic         memwr;
  logic         prgreq;
  logic         prgack;
  logic [13:0]  vmemaddr;
  logic [7:0]   chrrdata;
  logic         chrreq;
  logic         chrack;
  logic [20:0]  promaddr;
  logic [7:0]   promdata;
  logic         promreq;
  logic         promack;
  logic [20:0]  cromaddr;
  logic [7:0]   cromdata;
  logic         cromreq;
  logic         cromack;
  logic [127:0] header;
  logic [2:0]   mirr;

  int n_cmp = 0;
  int n_err = 0;

  mmc3 #(.PRGAW(21), .CHRAW(21), .A12LOW(3)) dut (
    .clk(clk), .reset(reset), .irq(irq),
    .memaddr(memaddr), .prgrdata(prgrdata), .memwdata(memwdata),
    .memwr(memwr), .prgreq(prgreq), .prgack(prgack),
    .vmemaddr(vmemaddr), .chrrdata(chrrdata), .chrreq(chrreq), .chrack(chrack),
    .promaddr(promaddr), .promdata(promdata), .promreq(promreq), .promack(promack),
    .cromaddr(cromaddr), .cromdata(cromdata), .cromreq(cromreq), .cromack(cromack),
    .header(header), .mirr(mirr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    memaddr = addr; memwdata = data; memwr = 1'b1; prgreq = 1'b1;
    @(negedge clk);
    prgreq = 1'b0; memwr = 1'b0;
  endtask

  task automatic prg_map(input string tag, input logic [15:0] addr, input logic [20:0] exp);
    memaddr = addr;
    #1;
    check(tag, 32'(promaddr), 32'(exp));
  endtask

  task automatic a12_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vmemaddr = 14'h0000;
    end
  endtask

  // One high cycle followed by one low cycle; effects are visible on return
  task automatic a12_hi();
    @(negedge clk);
    vmemaddr = 14'h1000;
    @(negedge clk);
    vmemaddr = 14'h0000;
    #1;
  endtask

  initial begin
    reset = 1'b1; memaddr = 16'h0000; memwdata = 8'h00; memwr = 1'b0; prgreq = 1'b0;
    vmemaddr = 14'h0000; chrreq = 1'b0; promdata = 8'h00; promack = 1'b0;
    cromdata = 8'h00; cromack = 1'b0;
    header = '0;
    header[38:32] = 7'd16;
    repeat (3) @(negedge clk);

    // Reset state and reset mapping
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_mirr", 32'(mirr), 32'(MIRRVER));
    prg_map("rst_prg_E000", 16'hE000, 21'h3E000);
    prg_map("rst_prg_C000", 16'hC000, 21'h3C000);
    vmemaddr = 14'h17FF;
    #1;
    check("rst_chr_17FF", 32'(cromaddr), 32'h17FF);
    promdata = 8'hA5; cromdata = 8'h5A; promack = 1'b1; cromack = 1'b1;
    prgreq = 1'b1; chrreq = 1'b1;
    #1;
    check("pass_prg", {23'd0, promreq, prgack, prgrdata}, {23'd0, 1'b1, 1'b1, 8'hA5});
    check("pass_chr", {23'd0, cromreq, chrack, chrrdata}, {23'd0, 1'b1, 1'b1, 8'h5A});
    prgreq = 1'b0; chrreq = 1'b0; promack = 1'b0; cromack = 1'b0;
    vmemaddr = 14'h0000;
    @(negedge clk);
    reset = 1'b0;

    // PRG mode swap
    cpu_write(16'h8000, 8'h46);
    cpu_write(16'h8001, 8'h05);
    prg_map("swap_C000", 16'hC000, 21'h0A000);
    prg_map("swap_8000", 16'h8000, 21'h3C000);
    prg_map("swap_E000", 16'hE000, 21'h3E000);
    cpu_write(16'h8000, 8'h06);
    prg_map("mode0_8000", 16'h8000, 21'h0A000);
    // Bank number masked by ROM size: 0x45 & 0x1F = 5
    cpu_write(16'h8001, 8'h45);
    prg_map("mask_8000", 16'h8000, 21'h0A000);

    // Held request writes once: R7 keeps the first data byte (9)
    cpu_write(16'h8000, 8'h07);
    @(negedge clk);
    memaddr = 16'h8001; memwdata = 8'h09; memwr = 1'b1; prgreq = 1'b1;
    @(negedge clk);
    memwdata = 8'h0C;
    @(negedge clk);
    memwdata = 8'h1F;
    @(negedge clk);
    prgreq = 1'b0; memwr = 1'b0;
    prg_map("held_A000", 16'hA000, 21'h12000);

    // Mirroring
    cpu_write(16'hA000, 8'h01);
    #1;
    check("mirr_hor", 32'(mirr), 32'(MIRRHOR));
    cpu_write(16'hA000, 8'h00);
    cpu_write(16'hA001, 8'hFF);
    #1;
    check("mirr_ver", 32'(mirr), 32'(MIRRVER));

    // CHR inversion
    cpu_write(16'h8000, 8'h00);
    cpu_write(16'h8001, 8'h0B);
    cpu_write(16'h8000, 8'h80);
    vmemaddr = 14'h1400;
    #1;
    check("chrinv_1400", 32'(cromaddr), 32'h02C00);
    vmemaddr = 14'h0123;
    #1;
    check("chrinv_0123", 32'(cromaddr), 32'h01123);
    vmemaddr = 14'h0000;

    // IRQ counter: latch 3, reload, enable, five edges
    chrreq = 1'b1;
    cpu_write(16'hC000, 8'h03);
    cpu_write(16'hC001, 8'h00);
    cpu_write(16'hE001, 8'h00);
    a12_low(3); a12_hi();
    check("e1_cnt", 32'(dut.cnt_q), 32'd3);
    check("e1_irq", 32'(irq), 32'd0);
    a12_low(3); a12_hi();
    check("e2_cnt", 32'(dut.cnt_q), 32'd2);
    a12_low(3); a12_hi();
    check("e3_cnt", 32'(dut.cnt_q), 32'd1);
    check("e3_irq", 32'(irq), 32'd0);
    a12_low(3); a12_hi();
    check("e4_cnt", 32'(dut.cnt_q), 32'd0);
    check("e4_irq", 32'(irq), 32'd1);
    a12_low(3); a12_hi();
    check("e5_cnt", 32'(dut.cnt_q), 32'd3);
    check("e5_irq_sticky", 32'(irq), 32'd1);
    cpu_write(16'hE000, 8'h00);
    #1;
    check("e000_clear", 32'(irq), 32'd0);

    // Collision: $E000 in the edge cycle where cnt reaches 0
    cpu_write(16'hC000, 8'h02);
    cpu_write(16'hC001, 8'h00);
    cpu_write(16'hE001, 8'h00);
    a12_low(3); a12_hi();
    check("col_cnt2", 32'(dut.cnt_q), 32'd2);
    a12_low(3); a12_hi();
    check("col_cnt1", 32'(dut.cnt_q), 32'd1);
    a12_low(3);
    @(negedge clk);
    vmemaddr = 14'h1000; memaddr = 16'hE000; memwr = 1'b1; prgreq = 1'b1;
    @(negedge clk);
    vmemaddr = 14'h0000; memwr = 1'b0; prgreq = 1'b0;
    #1;
    check("col_cnt0", 32'(dut.cnt_q), 32'd0);
    check("col_irq", 32'(irq), 32'd0);
    @(negedge clk);
    check("col_irq_stays", 32'(irq), 32'd0);

    // Filter: 2 low cycles do not qualify, 3 do
    a12_low(3); a12_hi();
    check("flt_edge_a", 32'(dut.cnt_q), 32'd2);
    a12_low(1); a12_hi();
    check("flt_2low", 32'(dut.cnt_q), 32'd2);
    a12_low(2); a12_hi();
    check("flt_3low", 32'(dut.cnt_q), 32'd1);

    // latch 0 with irqen: every edge raises irq
    cpu_write(16'hC000, 8'h00);
    cpu_write(16'hC001, 8'h00);
    cpu_write(16'hE001, 8'h00);
    a12_low(3); a12_hi();
    check("l0_irq_a", 32'(irq), 32'd1);
    cpu_write(16'hE000, 8'h00);
    cpu_write(16'hE001, 8'h00);
    #1;
    check("l0_cleared", 32'(irq), 32'd0);
    a12_low(3); a12_hi();
    check("l0_irq_b", 32'(irq), 32'd1);

    // Async reset mid-transfer: no clock edge needed, pass-throughs keep flowing
    cpu_write(16'h8000, 8'h06);
    cpu_write(16'h8001, 8'h05);
    prg_map("pre_rst_8000", 16'h8000, 21'h0A000);
    @(negedge clk);
    memaddr = 16'h8000; memwr = 1'b0; prgreq = 1'b1; promack = 1'b1; promdata = 8'h3C;
    #1;
    reset = 1'b1;
    #1;
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_map", 32'(promaddr), 32'h00000);
    check("arst_pass", {23'd0, promreq, prgack, prgrdata}, {23'd0, 1'b1, 1'b1, 8'h3C});
    @(negedge clk);
    reset = 1'b0; prgreq = 1'b0; promack = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
